// File: rtl/ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer driving a 4x16 register file.
// Optional trapping of undefined opcodes is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module ctrl_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [1:0]  rf_rn1,
  output logic [1:0]  rf_rn2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  output logic [1:0]  rf_wn,
  output logic        rf_w,
  output logic [15:0] rf_wd,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HLT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LDHI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] res_q, res_d;
  logic        req_q;
  logic        wr_q;
  logic        halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  logic [3:0] op_f;
  logic [1:0] rd_f;
  logic [1:0] rs1_f;
  logic [1:0] rs2_f;
  logic [7:0] imm_f;

  assign op_f  = ir_q[15:12];
  assign rd_f  = ir_q[11:10];
  assign rs1_f = ir_q[9:8];
  assign rs2_f = ir_q[7:6];
  assign imm_f = ir_q[7:0];

  // Port 1 reads rd for LDHI so the low byte of the destination can be preserved.
  function automatic logic [15:0] alu_result(
    input logic [3:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [7:0]  imm
  );
    logic [15:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_LDI:  r = {8'h00, imm};
      OP_LDHI: r = {imm, a[7:0]};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    res_d     = res_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_f)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_LDHI: begin
            res_d   = alu_result(op_f, rf_rd1, rf_rd2, imm_f);
            state_d = S_WB;
          end
          OP_NOP: state_d = S_FETCH;
          OP_JMP: begin
            pc_d    = imm_f;
            state_d = S_FETCH;
          end
          OP_BEQZ: begin
            if (rf_rd1 == 16'h0000) pc_d = imm_f;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HLT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HLT;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_WB:    state_d = S_FETCH;
      S_HLT:   state_d = S_HLT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      res_q     <= 16'h0000;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      halted_q  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      req_q     <= (state_d == S_FETCH);
      wr_q      <= (state_d == S_WB);
      halted_q  <= (state_d == S_HLT);
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign rf_rn1    = (op_f == OP_LDHI) ? rd_f : rs1_f;
  assign rf_rn2    = rs2_f;
  assign rf_wn     = rd_f;
  assign rf_w      = wr_q;
  assign rf_wd     = res_q;
  assign halted    = halted_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: models instruction memory and the register file,
// and checks write-backs and fetch addresses against hand-computed queues.
module tb_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [1:0]  rf_rn1, rf_rn2, rf_wn;
  logic [15:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_w;
  logic [7:0]  pc;
  logic        halted, illegal;

  always #5 clk = ~clk;

  ctrl_seq #(.RESET_PC(8'hFE)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_rn1(rf_rn1), .rf_rn2(rf_rn2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_wn(rf_wn), .rf_w(rf_w), .rf_wd(rf_wd),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  logic [15:0] mem [256];
  logic [15:0] rf [4];
  logic        rf_clr = 1'b1;
  logic        force_ack = 1'b0;
  int          wait_n = 0;
  int          wcnt = 0;

  assign imem_data = mem[imem_addr];
  assign imem_ack  = force_ack | (imem_req && (wcnt >= wait_n));
  assign rf_rd1    = rf[rf_rn1];
  assign rf_rd2    = rf[rf_rn2];

  always @(posedge clk) begin
    if (rf_clr) for (int i = 0; i < 4; i++) rf[i] <= 16'h1111;
    else if (rf_w) rf[rf_wn] <= rf_wd;
  end

  always @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req) wcnt <= wcnt + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [17:0] exp_wr[$];
  logic [7:0]  exp_fa[$];
  logic [17:0] e_wr;
  logic [7:0]  e_fa;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected write-backs and fetch addresses as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_w) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          $display("FAIL wb_unexpected: got wn=%0d wd=%h expected none", rf_wn, rf_wd);
        end else begin
          e_wr = exp_wr.pop_front();
          chk("wb_wn_wd", {14'd0, rf_wn, rf_wd}, {14'd0, e_wr});
        end
      end
      if (imem_req && imem_ack) begin
        if (exp_fa.size() == 0) begin
          n_chk++;
          $display("FAIL fetch_unexpected: got addr=%h expected none", imem_addr);
        end else begin
          e_fa = exp_fa.pop_front();
          chk("fetch_addr", {24'd0, imem_addr}, {24'd0, e_fa});
        end
      end
    end
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b000000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [7:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_clr = 1'b1;
    force_ack = 1'b0;
    tick();
    tick();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 8'hFE);
    chk("rst_pc", pc, 8'hFE);
    chk("rst_rf_w", rf_w, 0);
    chk("rst_rn_wn", {rf_rn1, rf_rn2, rf_wn}, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    rf_clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      tick();
      k++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic drained(input string tag);
    chk({tag, "_wb_queue_empty"}, exp_wr.size(), 0);
    chk({tag, "_fetch_queue_empty"}, exp_fa.size(), 0);
    exp_wr.delete();
    exp_fa.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prog [11];
    logic [7:0]  a;

    // A: basic sequence, timing, PC wrap and halt.
    clr_mem();
    wait_n = 0;
    mem[8'hFE] = enc_i(4'h6, 2'd1, 2'd0, 8'h05);
    mem[8'hFF] = enc_i(4'h6, 2'd2, 2'd0, 8'h03);
    mem[8'h00] = enc_r(4'h1, 2'd3, 2'd1, 2'd2);
    mem[8'h01] = 16'hF000;
    exp_fa.push_back(8'hFE); exp_fa.push_back(8'hFF);
    exp_fa.push_back(8'h00); exp_fa.push_back(8'h01);
    exp_wr.push_back({2'd1, 16'h0005});
    exp_wr.push_back({2'd2, 16'h0003});
    exp_wr.push_back({2'd3, 16'h0008});
    do_reset();
    tick(); tick(); tick();
    chk("first_wb_cycle", rf_w, 1);
    tick();
    chk("wb_one_cycle", rf_w, 0);
    tick(); tick();
    chk("wb_spacing", rf_w, 1);
    tick();
    chk("wrap_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
    wait_halt(60);
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_hold", {halted, imem_req, rf_w, pc}, {1'b1, 1'b0, 1'b0, 8'h02});
    end
    force_ack = 1'b0;
    chk("rf_r3", rf[3], 16'h0008);
    drained("A");

    // B: arithmetic, modulo wrap and LDHI byte merge.
    clr_mem();
    prog[0]  = enc_i(4'h6, 2'd1, 2'd0, 8'hFF);
    prog[1]  = enc_i(4'h7, 2'd1, 2'd0, 8'hFF);
    prog[2]  = enc_i(4'h6, 2'd2, 2'd0, 8'h01);
    prog[3]  = enc_r(4'h1, 2'd0, 2'd1, 2'd2);
    prog[4]  = enc_r(4'h2, 2'd0, 2'd2, 2'd1);
    prog[5]  = enc_i(4'h6, 2'd0, 2'd0, 8'hAB);
    prog[6]  = enc_i(4'h7, 2'd0, 2'd0, 8'hCD);
    prog[7]  = enc_r(4'h3, 2'd3, 2'd1, 2'd2);
    prog[8]  = enc_r(4'h4, 2'd3, 2'd0, 2'd2);
    prog[9]  = enc_r(4'h5, 2'd3, 2'd0, 2'd1);
    prog[10] = 16'hF000;
    a = 8'hFE;
    for (int i = 0; i < 11; i++) begin
      mem[a] = prog[i];
      exp_fa.push_back(a);
      a = a + 8'd1;
    end
    exp_wr.push_back({2'd1, 16'h00FF});
    exp_wr.push_back({2'd1, 16'hFFFF});
    exp_wr.push_back({2'd2, 16'h0001});
    exp_wr.push_back({2'd0, 16'h0000});
    exp_wr.push_back({2'd0, 16'h0002});
    exp_wr.push_back({2'd0, 16'h00AB});
    exp_wr.push_back({2'd0, 16'hCDAB});
    exp_wr.push_back({2'd3, 16'h0001});
    exp_wr.push_back({2'd3, 16'hCDAB});
    exp_wr.push_back({2'd3, 16'h3254});
    do_reset();
    wait_halt(100);
    drained("B");

    // C: wait states, BEQZ taken/not taken, undefined opcode, JMP.
    clr_mem();
    wait_n = 3;
    mem[8'hFE] = enc_i(4'h6, 2'd0, 2'd0, 8'h00);
    mem[8'hFF] = enc_i(4'h9, 2'd0, 2'd0, 8'h40);
    mem[8'h40] = enc_i(4'h6, 2'd0, 2'd0, 8'h01);
    mem[8'h41] = enc_i(4'h9, 2'd0, 2'd0, 8'h50);
    mem[8'h42] = 16'hC000;
    mem[8'h43] = 16'h0000;
    mem[8'h44] = enc_i(4'h8, 2'd0, 2'd0, 8'h60);
    mem[8'h60] = 16'hF000;
    exp_fa.push_back(8'hFE); exp_fa.push_back(8'hFF);
    exp_fa.push_back(8'h40); exp_fa.push_back(8'h41); exp_fa.push_back(8'h42);
`ifndef CTRL_ILLEGAL_TRAP_EN
    exp_fa.push_back(8'h43); exp_fa.push_back(8'h44); exp_fa.push_back(8'h60);
`endif
    exp_wr.push_back({2'd0, 16'h0000});
    exp_wr.push_back({2'd0, 16'h0001});
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wait_hold", {imem_req, imem_addr, pc}, {1'b1, 8'hFE, 8'hFE});
    end
    tick();
    chk("after_ack", {imem_req, pc}, {1'b0, 8'hFF});
    wait_halt(300);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_trap", {illegal, halted, pc}, {1'b1, 1'b1, 8'h43});
`else
    chk("illegal_as_nop", {illegal, pc}, {1'b0, 8'h61});
`endif
    drained("C");

    // D: asynchronous reset during write-back.
    clr_mem();
    wait_n = 0;
    mem[8'hFE] = enc_i(4'h6, 2'd1, 2'd0, 8'h77);
    mem[8'hFF] = 16'hF000;
    exp_fa.push_back(8'hFE);
    exp_wr.push_back({2'd1, 16'h0077});
    do_reset();
    tick(); tick(); tick();
    chk("d_in_wb", rf_w, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {rf_w, imem_req, halted, pc, rf_wd},
        {1'b0, 1'b0, 1'b0, 8'hFE, 16'h0000});
    tick();
    chk("no_write_on_reset", rf[1], 16'h1111);
    exp_fa.push_back(8'hFE); exp_fa.push_back(8'hFF);
    exp_wr.push_back({2'd1, 16'h0077});
    rst = 1'b0;
    wait_halt(50);
    chk("rf_r1_after_rerun", rf[1], 16'h0077);
    drained("D");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer sitting directly upstream of the 4×16-bit register file. It fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them. It drives the register file's read ports (`rn1`/`rn2`), computes results from `rd1`/`rd2`, and produces the write-back controls (`wn`/`w`/`wd`) that the register file consumes.

## Interface
- `RESET_PC`, default 8'h00, PC value loaded on reset.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 8: fetch address, equals `pc`.
- `imem_ack` in 1: memory has `imem_data` valid this cycle.
- `imem_data` in 16: instruction word.
- `rf_rn1` out 2: register file read port 1 select.
- `rf_rn2` out 2: register file read port 2 select.
- `rf_rd1` in 16: register file read data 1.
- `rf_rd2` in 16: register file read data 2. Both read ports are combinational.
- `rf_wn` out 2: write select.
- `rf_w` out 1: write enable.
- `rf_wd` out 16: write data.
- `pc` out 8: program counter.
- `halted` out 1: sequencer stopped.
- `illegal` out 1: undefined opcode trapped. Tied 0 unless `CTRL_ILLEGAL_TRAP_EN` is defined.

## Operation
- Instruction fields: `op`=ir[15:12], `rd`=ir[11:10], `rs1`=ir[9:8], `rs2`=ir[7:6], `imm`=ir[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs1+rs2.
  - 2 SUB: rd=rs1-rs2.
  - 3 AND, 4 OR, 5 XOR: rd=rs1 op rs2.
  - 6 LDI: rd={8'h00,imm}.
  - 7 LDHI: rd={imm,rd[7:0]}.
  - 8 JMP: pc=imm.
  - 9 BEQZ: if rs1==0 then pc=imm.
  - F HALT.
  - A–E undefined.
- Arithmetic is 16-bit modulo; carry and borrow are discarded.
- Read selects are driven from `ir`:
  - `rf_rn1` = `rd` for LDHI, otherwise `rs1`.
  - `rf_rn2` = `rs2`.
- `rf_wn` = `rd` from `ir`. `rf_wd` = registered result `res`.
- `rf_w`=1 only in state WB.
- States:
  - IDLE: entered from reset; unconditionally goes to FETCH next cycle.
  - FETCH: `imem_req`=1. On a cycle with `imem_ack`=1: `ir`<=`imem_data`, `pc`<=`pc`+1 (wraps 8'hFF→8'h00), go to EXEC. Otherwise stay in FETCH.
  - EXEC:
    - ADD–LDHI: `res`<=result, go to WB.
    - NOP: go to FETCH.
    - JMP: `pc`<=imm, go to FETCH.
    - BEQZ: `pc`<=imm if `rf_rd1`==0, go to FETCH.
    - HALT: go to HLT.
    - Undefined opcode: see Configuration.
  - WB: `rf_w`=1 for exactly one cycle, go to FETCH.
  - HLT: `halted`=1, `imem_req`=0, `rf_w`=0. Terminal until `rst`.
- The register file write lands on the WB posedge, so the next EXEC reads the updated value. No hazard logic is needed.
- Reset values: state IDLE, `pc`=`RESET_PC`, `ir`=0, `res`=0. All outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `rf_rn1`=`rf_rn2`=`rf_wn`=0, `rf_w`=0, `rf_wd`=0, `halted`=0, `illegal`=0.

## Timing
- Handshake:
  - `imem_req` stays high, with `imem_addr` stable, until the cycle `imem_ack` is sampled high.
  - `imem_ack` with `imem_req` low is ignored.
  - Zero-wait memory gives `ack` in the first FETCH cycle.
- Cycles per instruction with zero-wait memory:
  - Non-writeback (NOP/JMP/BEQZ): FETCH+EXEC = 2.
  - Writeback (ADD–LDHI): FETCH+EXEC+WB = 3.
  - Each wait cycle adds 1.
- First fetch is presented the cycle after reset deasserts, following the IDLE cycle.
- Reset asserted mid-handshake or mid-WB: all outputs drop to reset values immediately (asynchronous). No write occurs, and the pending fetch is abandoned.
- `pc` wraparound: `pc`+1 from 8'hFF yields 8'h00. A JMP/BEQZ taken target overrides the increment.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An undefined opcode in EXEC sets `illegal`=1 and goes to HLT (`halted`=1).
  - `illegal` stays 1 until reset.
- `CTRL_ILLEGAL_TRAP_EN` not defined:
  - Undefined opcodes execute as NOP (EXEC→FETCH).
  - `illegal` is constant 0.

## Test plan
- Reset then program {LDI r1,8'h05; LDI r2,8'h03; ADD r3,r1,r2} with zero-wait memory -> `rf_w` pulses with `wn`/`wd` = 1/0005, 2/0003, 3/0008. Pulses fall 3 cycles apart; the first `rf_w` is on cycle 4 after reset release.
- r1=FFFF, r2=0001: ADD r0 -> 0000; SUB r0,r2,r1 -> 0002. LDI r0,AB then LDHI r0,CD -> `rf_wd`=CDAB.
- `imem_ack` delayed 3 cycles -> `imem_req`/`imem_addr` held stable for 4 cycles; no `ir` or `pc` change before `ack`.
- `RESET_PC`=FE, program NOP,NOP at FE/FF -> third fetch address 00. BEQZ r0 with r0=0, imm 40 -> next `imem_addr` 40. With r0=1 -> next `imem_addr` is `pc`+1.
- HALT -> `halted`=1, `imem_req`=0 indefinitely. `rst` pulse mid-WB -> `rf_w` drops immediately, `pc`=`RESET_PC`, `halted`=0.
- Opcode C -> with `CTRL_ILLEGAL_TRAP_EN`: `illegal`=`halted`=1. Without it: next fetch at `pc`+1, `illegal`=0.
